// File: rtl/rv32_pkg.sv
// Shared RV32 register-file constants, writeback requester indices and the
// writeback request record used by the writeback arbiter.
package rv32_pkg;

  localparam int XLEN              = 32;
  localparam int REG_FILE_DEPTH    = 32;
  localparam int REG_FILE_ADDR_LEN = $clog2(REG_FILE_DEPTH);

  localparam int REQ_ALU = 0;
  localparam int REQ_LSU = 1;
  localparam int REQ_CSR = 2;

  typedef struct packed {
    logic [REG_FILE_ADDR_LEN-1:0] addr;
    logic [XLEN-1:0]              data;
  } wb_req_t;

  // Round-robin successor of idx among n requesters.
  function automatic int rr_next(input int idx, input int n);
    return (idx + 1 >= n) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/regfile_wb_arbiter_if.sv
// Writeback bus: per-requester valid/ready/addr/data handshakes on the
// execute side and the registered write port on the register-file side.
interface regfile_wb_arbiter_if
  import rv32_pkg::*;
#(
  parameter int NUM_REQ = 3
) ();

  logic [NUM_REQ-1:0]                   req_valid;
  logic [NUM_REQ-1:0]                   req_ready;
  logic [NUM_REQ*REG_FILE_ADDR_LEN-1:0] req_addr;
  logic [NUM_REQ*XLEN-1:0]              req_data;
  logic                                 wr_en;
  logic [REG_FILE_ADDR_LEN-1:0]         wr_addr;
  logic [XLEN-1:0]                      wr_data;

  modport master (
    output req_valid, req_addr, req_data,
    input  req_ready, wr_en, wr_addr, wr_data
  );

  modport slave (
    input  req_valid, req_addr, req_data,
    output req_ready, wr_en, wr_addr, wr_data
  );

endinterface

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: scans from rr_ptr upward (wrapping) and
// grants the first valid requester unless hold is asserted.
module rr_arbiter #(
  parameter  int NUM_REQ = 3,
  localparam int IDX_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   rr_ptr,
  input  logic               hold,
  output logic [NUM_REQ-1:0] grant,
  output logic [IDX_W-1:0]   grant_idx,
  output logic               grant_vld
);

  always_comb begin
    int               idx;
    logic [IDX_W-1:0] idx_s;
    idx       = 0;
    idx_s     = '0;
    grant     = '0;
    grant_idx = '0;
    grant_vld = 1'b0;
    if (!hold) begin
      for (int k = 0; k < NUM_REQ; k++) begin
        idx = int'(rr_ptr) + k;
        if (idx >= NUM_REQ) idx = idx - NUM_REQ;
        idx_s = IDX_W'(idx);
        if (!grant_vld && req[idx_s]) begin
          grant[idx_s] = 1'b1;
          grant_idx    = idx_s;
          grant_vld    = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Writeback arbiter for the single register-file write port: round-robin grant
// plus a one-entry registered writeback stage. Define WB_BYPASS_EN to add the
// rs1/rs2 bypass compares against the writeback stage.
module regfile_wb_arbiter
  import rv32_pkg::*;
#(
  parameter int NUM_REQ = 3
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         wb_hold,
`ifdef WB_BYPASS_EN
  input  logic [REG_FILE_ADDR_LEN-1:0] rs1,
  input  logic [REG_FILE_ADDR_LEN-1:0] rs2,
  output logic                         byp_hit_1,
  output logic                         byp_hit_2,
  output logic [XLEN-1:0]              byp_data_1,
  output logic [XLEN-1:0]              byp_data_2,
`endif
  regfile_wb_arbiter_if.slave          bus
);

  localparam int IDX_W = $clog2(NUM_REQ);

  logic [IDX_W-1:0]             rr_ptr;
  logic [NUM_REQ-1:0]           grant;
  logic [IDX_W-1:0]             grant_idx;
  logic                         grant_vld;
  wb_req_t                      reqs [NUM_REQ];
  wb_req_t                      sel;

  logic                         wb_vld_p1;
  logic [REG_FILE_ADDR_LEN-1:0] wb_addr_p1;
  logic [XLEN-1:0]              wb_data_p1;

  for (genvar i = 0; i < NUM_REQ; i++) begin : g_unpack
    assign reqs[i].addr = bus.req_addr[i*REG_FILE_ADDR_LEN +: REG_FILE_ADDR_LEN];
    assign reqs[i].data = bus.req_data[i*XLEN +: XLEN];
  end

  // Reset doubles as a hold so no request is accepted while it is asserted.
  rr_arbiter #(
    .NUM_REQ (NUM_REQ)
  ) u_arb (
    .req       (bus.req_valid),
    .rr_ptr    (rr_ptr),
    .hold      (wb_hold | reset),
    .grant     (grant),
    .grant_idx (grant_idx),
    .grant_vld (grant_vld)
  );

  assign bus.req_ready = grant;
  assign sel           = reqs[grant_idx];

  // Stage p1: registered writeback; x0 writes are consumed without wr_en.
  always_ff @(posedge clk) begin
    if (reset) begin
      rr_ptr     <= '0;
      wb_vld_p1  <= 1'b0;
      wb_addr_p1 <= '0;
      wb_data_p1 <= '0;
    end else begin
      wb_vld_p1 <= 1'b0;
      if (grant_vld) begin
        rr_ptr     <= IDX_W'(rr_next(int'(grant_idx), NUM_REQ));
        wb_vld_p1  <= (sel.addr != '0);
        wb_addr_p1 <= sel.addr;
        wb_data_p1 <= sel.data;
      end
    end
  end

  assign bus.wr_en   = wb_vld_p1;
  assign bus.wr_addr = wb_addr_p1;
  assign bus.wr_data = wb_data_p1;

`ifdef WB_BYPASS_EN
  // Covers the cycle where the register file still returns the stale value.
  assign byp_hit_1  = wb_vld_p1 && (wb_addr_p1 == rs1) && (rs1 != '0);
  assign byp_hit_2  = wb_vld_p1 && (wb_addr_p1 == rs2) && (rs2 != '0);
  assign byp_data_1 = wb_data_p1;
  assign byp_data_2 = wb_data_p1;
`endif

endmodule
